// File: rtl/imm_gen_stage_pkg.sv
// Shared definitions for the immediate-generation stage and its decoder.
// Immediate format encodings, the default XLEN and the handshake states.
package imm_gen_stage_pkg;

    localparam int unsigned IMM_TYPE_W   = 3;
    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [IMM_TYPE_W-1:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_Z = 3'd5
    } imm_type_e;

    // Encoded as {out_valid, skid_valid}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL1 = 2'b10,
        ST_FULL2 = 2'b11
    } stage_state_e;

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational RV immediate decoder: instruction word + format -> XLEN immediate.
// Shared with the IDU; reserved formats yield zero and flag illegal.
module imm_decode
    import imm_gen_stage_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]           inst_i,
    input  logic [IMM_TYPE_W-1:0] imm_type_i,
    output logic [XLEN-1:0]       imm_o,
    output logic                  illegal_o
);

    logic        s;
    logic [31:0] imm32;
    logic [6:0]  unused_opcode;

    assign s             = inst_i[31];
    assign unused_opcode = inst_i[6:0];

    always_comb begin
        imm32     = '0;
        illegal_o = 1'b0;
        case (imm_type_e'(imm_type_i))
            IMM_I:   imm32 = {{20{s}}, inst_i[31:20]};
            IMM_S:   imm32 = {{20{s}}, inst_i[31:25], inst_i[11:7]};
            IMM_B:   imm32 = {{19{s}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            IMM_U:   imm32 = {inst_i[31:12], 12'b0};
            IMM_J:   imm32 = {{11{s}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            IMM_Z:   imm32 = {27'b0, inst_i[19:15]};
            default: illegal_o = 1'b1;
        endcase
        // Bit 31 already carries the right fill (zero for Z), so one sign extension covers XLEN=64
        imm_o = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered valid/ready immediate-generation stage between IFU and IDU/EXU.
// SKID=1 adds a second entry so in_ready depends only on registered state.
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned TAG_W = 32,
    parameter bit          SKID  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [IMM_TYPE_W-1:0] in_imm_type,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_imm,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_illegal
);

    stage_state_e     state_q, state_d;
    logic             skid_valid;
    logic             accept;
    logic             load_out, load_from_skid, load_skid;

    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;

    logic [XLEN-1:0]  out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
    logic             out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .inst_i     (in_inst),
        .imm_type_i (in_imm_type),
        .imm_o      (dec_imm),
        .illegal_o  (dec_ill)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL1;
            ST_FULL1: begin
                if (out_ready && !accept)      state_d = ST_EMPTY;
                else if (!out_ready && accept) state_d = ST_FULL2;
            end
            ST_FULL2: if (out_ready) state_d = ST_FULL1;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid      = (state_q == ST_FULL1) || (state_q == ST_FULL2);
        skid_valid     = (state_q == ST_FULL2);
        in_ready       = SKID ? !skid_valid : (!out_valid || out_ready);
        accept         = in_valid && in_ready;
        load_from_skid = skid_valid && out_ready;
        load_out       = accept && (!out_valid || out_ready);
        load_skid      = accept && out_valid && !out_ready;
    end

    // Skid contents take priority; FULL2 never accepts, so the two loads never collide
    always_comb begin
        out_imm_d  = out_imm_q;
        out_tag_d  = out_tag_q;
        out_ill_d  = out_ill_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_ill_d = skid_ill_q;
        if (load_from_skid) begin
            out_imm_d = skid_imm_q;
            out_tag_d = skid_tag_q;
            out_ill_d = skid_ill_q;
        end else if (load_out) begin
            out_imm_d = dec_imm;
            out_tag_d = in_tag;
            out_ill_d = dec_ill;
        end
        if (load_skid) begin
            skid_imm_d = dec_imm;
            skid_tag_d = in_tag;
            skid_ill_d = dec_ill;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_imm_q  <= '0;
            out_tag_q  <= '0;
            out_ill_q  <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            out_imm_q  <= out_imm_d;
            out_tag_q  <= out_tag_d;
            out_ill_q  <= out_ill_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
            skid_ill_q <= skid_ill_d;
        end
    end

    assign out_imm     = out_imm_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: 32-bit skid instance and 64-bit single-register instance.
// Vector tables cover every format; hand sequences cover backpressure and mid-transfer reset.
module tb_imm_gen_stage;
    import imm_gen_stage_pkg::*;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  typ;
        logic [31:0] tag;
        logic [63:0] imm;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_inst, in_tag, out_imm, out_tag;
    logic [2:0]  in_imm_type;

    logic        in_valid64, in_ready64, out_valid64, out_ready64, out_illegal64;
    logic [31:0] in_inst64;
    logic [2:0]  in_imm_type64;
    logic [15:0] in_tag64, out_tag64;
    logic [63:0] out_imm64;

    int checks = 0;
    int errors = 0;

    vec_t v32[12];
    vec_t v64[6];

    logic [31:0] got_q[$];

    imm_gen_stage #(.XLEN(32), .TAG_W(32), .SKID(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_imm_type (in_imm_type),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(16), .SKID(1'b0)) dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid64),
        .in_ready    (in_ready64),
        .in_inst     (in_inst64),
        .in_imm_type (in_imm_type64),
        .in_tag      (in_tag64),
        .out_valid   (out_valid64),
        .out_ready   (out_ready64),
        .out_imm     (out_imm64),
        .out_tag     (out_tag64),
        .out_illegal (out_illegal64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Output handshakes observed on the 32-bit instance
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back(out_tag);
    end

    // Upstream must hold a stalled beat unchanged
    logic        held = 1'b0;
    logic [31:0] h_inst, h_tag;
    logic [2:0]  h_type;
    always @(posedge clk) begin
        if (held && rst_n &&
            (!in_valid || in_inst !== h_inst || in_tag !== h_tag || in_imm_type !== h_type)) begin
            errors++;
            $display("FAIL upstream_hold: in_valid %b tag %h required held tag %h", in_valid, in_tag, h_tag);
        end
        held   <= in_valid && !in_ready && rst_n;
        h_inst <= in_inst;
        h_tag  <= in_tag;
        h_type <= in_imm_type;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic drive32(input logic [31:0] inst, input logic [2:0] typ, input logic [31:0] tag);
        in_valid    = 1'b1;
        in_inst     = inst;
        in_imm_type = typ;
        in_tag      = tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        v32[0]  = '{32'hFFF00093, 3'd0, 32'h0000_1000, 64'hFFFFFFFF, 1'b0};
        v32[1]  = '{32'hFE20AE23, 3'd1, 32'h0000_1004, 64'hFFFFFFFC, 1'b0};
        v32[2]  = '{32'hFE000CE3, 3'd2, 32'h0000_1008, 64'hFFFFFFF8, 1'b0};
        v32[3]  = '{32'hFFDFF0EF, 3'd4, 32'h0000_100C, 64'hFFFFFFFC, 1'b0};
        v32[4]  = '{32'h123452B7, 3'd3, 32'h0000_1010, 64'h12345000, 1'b0};
        v32[5]  = '{32'h800F8073, 3'd5, 32'h0000_1014, 64'h0000001F, 1'b0};
        v32[6]  = '{32'hFFFFFFFF, 3'd7, 32'h0000_1018, 64'h00000000, 1'b1};
        v32[7]  = '{32'h00500113, 3'd0, 32'h0000_101C, 64'h00000005, 1'b0};
        v32[8]  = '{32'h00112423, 3'd1, 32'h0000_1020, 64'h00000008, 1'b0};
        v32[9]  = '{32'h12345678, 3'd6, 32'h0000_1024, 64'h00000000, 1'b1};
        v32[10] = '{32'h00208463, 3'd2, 32'h0000_1028, 64'h00000008, 1'b0};
        v32[11] = '{32'h0100006F, 3'd4, 32'hDEAD_BEEF, 64'h00000010, 1'b0};

        v64[0] = '{32'hFFF00093, 3'd0, 32'h0000_0001, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
        v64[1] = '{32'h800002B7, 3'd3, 32'h0000_0002, 64'hFFFFFFFF_80000000, 1'b0};
        v64[2] = '{32'h123452B7, 3'd3, 32'h0000_0003, 64'h00000000_12345000, 1'b0};
        v64[3] = '{32'hFE20AE23, 3'd1, 32'h0000_0004, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
        v64[4] = '{32'h800F8073, 3'd5, 32'h0000_0005, 64'h00000000_0000001F, 1'b0};
        v64[5] = '{32'hFFFFFFFF, 3'd7, 32'h0000_0006, 64'h00000000_00000000, 1'b1};

        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_inst       = '0;
        in_imm_type   = '0;
        in_tag        = '0;
        out_ready     = 1'b1;
        in_valid64    = 1'b0;
        in_inst64     = '0;
        in_imm_type64 = '0;
        in_tag64      = '0;
        out_ready64   = 1'b1;

        repeat (2) tick();
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst64_out_valid", out_valid64, 0);
        chk("rst64_out_imm", out_imm64, 0);
        tick();
        chk("idle_in_ready", in_ready, 1);

        // Back-to-back, one beat per cycle, 32-bit skid instance
        for (int i = 0; i < 12; i++) begin
            drive32(v32[i].inst, v32[i].typ, v32[i].tag);
            chk($sformatf("b2b_in_ready_%0d", i), in_ready, 1);
            tick();
            chk($sformatf("v32_valid_%0d", i), out_valid, 1);
            chk($sformatf("v32_imm_%0d", i), out_imm, v32[i].imm);
            chk($sformatf("v32_tag_%0d", i), out_tag, v32[i].tag);
            chk($sformatf("v32_ill_%0d", i), out_illegal, v32[i].ill);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", out_valid, 0);

        // Backpressure: tag 1 on out, tag 2 in skid, tag 3 stalled
        got_q.delete();
        out_ready = 1'b0;
        drive32(32'hFFF00093, 3'd0, 32'd1);
        tick();
        chk("bp_valid_1", out_valid, 1);
        chk("bp_tag_1", out_tag, 1);
        chk("bp_ready_full1", in_ready, 1);
        drive32(32'h123452B7, 3'd3, 32'd2);
        tick();
        chk("bp_tag_hold_full2", out_tag, 1);
        chk("bp_ready_full2", in_ready, 0);
        drive32(32'hFFDFF0EF, 3'd4, 32'd3);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("bp_stall_valid_%0d", c), out_valid, 1);
            chk($sformatf("bp_stall_tag_%0d", c), out_tag, 1);
            chk($sformatf("bp_stall_imm_%0d", c), out_imm, 64'hFFFFFFFF);
            chk($sformatf("bp_stall_ready_%0d", c), in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_skid_to_out_tag", out_tag, 2);
        chk("bp_skid_to_out_imm", out_imm, 64'h12345000);
        chk("bp_ready_after_pop", in_ready, 1);
        tick();
        chk("bp_tag_3", out_tag, 3);
        chk("bp_imm_3", out_imm, 64'hFFFFFFFC);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", out_valid, 0);
        chk("bp_order_count", got_q.size(), 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("bp_order_%0d", k), (k < got_q.size()) ? got_q[k] : 'x, k + 1);

        // Reset while FULL2
        got_q.delete();
        out_ready = 1'b0;
        drive32(32'h00500113, 3'd0, 32'd4);
        tick();
        drive32(32'h00112423, 3'd1, 32'd5);
        tick();
        chk("rstmid_full2_ready", in_ready, 0);
        rst_n = 1'b0;
        tick();
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_in_ready", in_ready, 1);
        chk("rstmid_out_tag", out_tag, 0);
        chk("rstmid_out_imm", out_imm, 0);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("rstmid_quiet_%0d", c), out_valid, 0);
        end
        chk("rstmid_no_stale", got_q.size(), 0);
        drive32(32'h0100006F, 3'd4, 32'd6);
        tick();
        in_valid = 1'b0;
        chk("rstmid_recover_tag", out_tag, 6);
        chk("rstmid_recover_imm", out_imm, 64'h10);
        tick();

        // 64-bit single-register instance, back-to-back
        for (int i = 0; i < 6; i++) begin
            in_valid64    = 1'b1;
            in_inst64     = v64[i].inst;
            in_imm_type64 = v64[i].typ;
            in_tag64      = v64[i].tag[15:0];
            chk($sformatf("b2b64_in_ready_%0d", i), in_ready64, 1);
            tick();
            chk($sformatf("v64_valid_%0d", i), out_valid64, 1);
            chk($sformatf("v64_imm_%0d", i), out_imm64, v64[i].imm);
            chk($sformatf("v64_tag_%0d", i), out_tag64, v64[i].tag[15:0]);
            chk($sformatf("v64_ill_%0d", i), out_illegal64, v64[i].ill);
        end
        in_valid64 = 1'b0;
        tick();
        chk("drain64_valid", out_valid64, 0);

        // Single-register in_ready follows out_ready combinationally
        out_ready64   = 1'b0;
        in_valid64    = 1'b1;
        in_inst64     = 32'h00500113;
        in_imm_type64 = 3'd0;
        in_tag64      = 16'h0077;
        tick();
        in_valid64 = 1'b0;
        chk("s0_valid", out_valid64, 1);
        chk("s0_in_ready_stalled", in_ready64, 0);
        out_ready64 = 1'b1;
        #1;
        chk("s0_in_ready_released", in_ready64, 1);
        tick();
        chk("s0_drained", out_valid64, 0);
        chk("s0_tag_kept", out_tag64, 16'h0077);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
